// File: rtl/imem_loader.sv
// Byte-serial boot loader: parses MAGIC/addr/len/payload/checksum frames from a
// valid/ready byte port and writes the payload into instruction memory.
module imem_loader #(
  parameter logic [7:0] MAGIC = 8'hA5,
  parameter int         AW    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_byte_i,
  output logic          in_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          hold_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_d;
  logic [AW-1:0] maddr_d;
  logic [7:0]    wdata_d;

  // NOTE: every *_d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    maddr_d = mem_addr_o;
    wdata_d = mem_wdata_o;

    if (in_valid_i) begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (in_byte_i == MAGIC) begin
            state_d = ADDR;
            addr_d  = '0;
            len_d   = '0;
            sum_d   = '0;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          // Right shift puts byte k at [8k+7:8k] once all eight are in.
          addr_d = {in_byte_i, addr_q[63:8]};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = LEN;
            cnt_d   = '0;
          end
        end
        LEN: begin
          len_d = {in_byte_i, len_q[15:8]};
          if (cnt_q[0]) begin
            cnt_d   = '0;
            state_d = (len_d != 16'd0) ? DATA : CSUM;
          end else begin
            cnt_d = 3'd1;
          end
        end
        DATA: begin
          we_d    = 1'b1;
          maddr_d = addr_q[AW-1:0];
          wdata_d = in_byte_i;
          addr_d  = addr_q + 64'd1;
          sum_d   = sum_q + in_byte_i;
          len_d   = len_q - 16'd1;
          if (len_q == 16'd1) state_d = CSUM;
        end
        CSUM: state_d = (in_byte_i == sum_q) ? DONE : ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= maddr_d;
      mem_wdata_o <= wdata_d;
    end
  end

  // Status flags decode straight from the state register, so reset reaches
  // them asynchronously along with the state.
  assign in_ready_o = 1'b1;
  assign hold_o     = (state_q != DONE);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);

endmodule
